// File: rtl/operand_select_seq_if.sv
// Request, register-file and operand-stream signals of operand_select_seq.
// master: decoder/consumer side. slave: the selector.
interface operand_select_seq_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned SEL_WIDTH  = 4
);
    logic                           start;
    logic                           ready;
    logic [SEL_WIDTH-1:0]           sel_1;
    logic [SEL_WIDTH-1:0]           sel_2;
    logic [DATA_WIDTH-1:0]          imm_data;
    logic [NUM_REGS*DATA_WIDTH-1:0] regs_in;
    logic                           flush;
    logic [DATA_WIDTH-1:0]          out_data;
    logic                           out_valid;
    logic                           out_ready;
    logic                           out_index;
    logic                           out_imm;
    logic                           out_err;

    modport master (
        output start, sel_1, sel_2, imm_data, regs_in, flush, out_ready,
        input  ready, out_data, out_valid, out_index, out_imm, out_err
    );

    modport slave (
        input  start, sel_1, sel_2, imm_data, regs_in, flush, out_ready,
        output ready, out_data, out_valid, out_index, out_imm, out_err
    );
endinterface

// File: rtl/operand_select_seq.sv
// Sequenced operand selector: accepts one request with up to two selectors and
// streams the selected operands (operand 0, then operand 1) over valid/ready.
// All stream outputs are registered; ready depends only on the state register.
module operand_select_seq #(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          NUM_REGS   = 8,
    parameter int unsigned          SEL_WIDTH  = 4,
    parameter logic [SEL_WIDTH-1:0] IMM_CODE   = 4'hF
) (
    input logic                 clock,
    input logic                 reset,
    operand_select_seq_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StOp1, StOp2} state_e;

    state_e                state_q;
    logic [SEL_WIDTH-1:0]  sel1_q;
    logic [SEL_WIDTH-1:0]  sel2_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;
    logic                  out_index_q;
    logic                  out_imm_q;
    logic                  out_err_q;

    logic [SEL_WIDTH-1:0]  cur_sel;
    int unsigned           cur_sel_w;
    logic [DATA_WIDTH-1:0] dec_data;
    logic                  dec_imm;
    logic                  dec_err;
    logic                  stalled;

    assign stalled = out_valid_q && !bus.out_ready;

    // Decode the selector for the operand the current state would load;
    // register values are taken live from regs_in in the load cycle.
    always_comb begin
        cur_sel   = (state_q == StOp2) ? sel2_q : sel1_q;
        cur_sel_w = 32'(cur_sel);
        dec_data  = '0;
        dec_imm   = 1'b0;
        dec_err   = 1'b0;
        if (cur_sel == IMM_CODE) begin
            dec_data = imm_q;
            dec_imm  = 1'b1;
        end else if (cur_sel_w > NUM_REGS) begin
            dec_err = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (cur_sel_w == k + 1) begin
                    dec_data = bus.regs_in[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Request FSM with registered output beat; flush outranks everything else.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            sel1_q      <= '0;
            sel2_q      <= '0;
            imm_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= 1'b0;
            out_imm_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else if (bus.flush) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
        end else begin
            // A handshake retires the beat; a load below overrides this.
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        sel1_q  <= bus.sel_1;
                        sel2_q  <= bus.sel_2;
                        imm_q   <= bus.imm_data;
                        state_q <= StOp1;
                    end
                end
                StOp1: begin
                    if (!stalled) begin
                        if (sel1_q != '0) begin
                            out_data_q  <= dec_data;
                            out_imm_q   <= dec_imm;
                            out_err_q   <= dec_err;
                            out_index_q <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                        state_q <= (sel2_q != '0) ? StOp2 : StIdle;
                    end
                end
                StOp2: begin
                    if (!stalled) begin
                        out_data_q  <= dec_data;
                        out_imm_q   <= dec_imm;
                        out_err_q   <= dec_err;
                        out_index_q <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ready     = (state_q == StIdle);
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_index = out_index_q;
    assign bus.out_imm   = out_imm_q;
    assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_operand_select_seq.sv
// Bench for operand_select_seq: directed scenarios plus randomized requests
// scored against a selector-rule model. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_operand_select_seq;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    operand_select_seq_if #(.DATA_WIDTH(32), .NUM_REGS(8), .SEL_WIDTH(4)) bus ();

    operand_select_seq #(
        .DATA_WIDTH(32),
        .NUM_REGS  (8),
        .SEL_WIDTH (4),
        .IMM_CODE  (4'hF)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] regs_m [8];
    // {ready, out_valid, out_index, out_imm, out_err, out_data}
    logic [36:0] obs;
    logic [36:0] exp;
    assign obs = {bus.ready, bus.out_valid, bus.out_index, bus.out_imm, bus.out_err,
                  bus.out_data};

    task automatic drive_regs();
        for (int k = 0; k < 8; k++) bus.regs_in[k*32 +: 32] = regs_m[k];
    endtask

    task automatic set_regs_base();
        for (int k = 0; k < 8; k++) regs_m[k] = 32'h1000 + k;
        drive_regs();
    endtask

    // Presents a request for one cycle; returns at the falling edge after acceptance.
    task automatic start_req(input logic [3:0] s1, input logic [3:0] s2, input logic [31:0] imm);
        bus.sel_1    = s1;
        bus.sel_2    = s2;
        bus.imm_data = imm;
        bus.start    = 1'b1;
        @(negedge clock);
        bus.start    = 1'b0;
        bus.sel_1    = 4'($urandom);
        bus.sel_2    = 4'($urandom);
        bus.imm_data = $urandom;
    endtask

    // Expected beat {valid, index, imm, err, data} from the selector rules.
    function automatic logic [35:0] beat_of(input logic [3:0] s, input logic idx,
                                            input logic [31:0] imm);
        if (s == 4'hF) return {1'b1, idx, 1'b1, 1'b0, imm};
        if (s > 4'd8) return {1'b1, idx, 1'b0, 1'b1, 32'h0};
        return {1'b1, idx, 1'b0, 1'b0, regs_m[s - 4'd1]};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        tests++;
        if (obs[35:0] !== 36'h0) begin
            fails++; $display("FAIL reset_outputs got=%h want=%h", obs[35:0], 36'h0);
        end
        reset = 1'b0;
        @(negedge clock);
        tests++; exp = {1'b1, 36'h0};
        if (obs !== exp) begin fails++; $display("FAIL reset_release got=%h want=%h", obs, exp); end
    endtask

    task automatic test_two_regs();
        set_regs_base();
        bus.out_ready = 1'b1;
        start_req(4'd1, 4'd2, 32'h0);
        tests++;
        if (obs[36:35] !== 2'b00) begin
            fails++; $display("FAIL two_regs_t1 got=%b want=00", obs[36:35]);
        end
        @(negedge clock);
        tests++; exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000};
        if (obs !== exp) begin fails++; $display("FAIL two_regs_beat0 got=%h want=%h", obs, exp); end
        @(negedge clock);
        tests++; exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1001};
        if (obs !== exp) begin fails++; $display("FAIL two_regs_beat1 got=%h want=%h", obs, exp); end
        @(negedge clock);
        tests++;
        if (obs[36:35] !== 2'b10) begin
            fails++; $display("FAIL two_regs_done got=%b want=10", obs[36:35]);
        end
    endtask

    task automatic test_imm_err();
        bus.out_ready = 1'b1;
        start_req(4'hF, 4'h9, 32'hDEADBEEF);
        @(negedge clock);
        tests++; exp = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
        if (obs !== exp) begin fails++; $display("FAIL imm_beat got=%h want=%h", obs, exp); end
        @(negedge clock);
        tests++; exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
        if (obs !== exp) begin fails++; $display("FAIL err_beat got=%h want=%h", obs, exp); end
        @(negedge clock);
        tests++;
        if (obs[35] !== 1'b0) begin fails++; $display("FAIL imm_err_done got=%b want=0", obs[35]); end
    endtask

    task automatic test_backpressure();
        set_regs_base();
        bus.out_ready = 1'b0;
        start_req(4'd3, 4'd4, 32'h0);
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            tests++; exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1002};
            if (obs !== exp) begin
                fails++; $display("FAIL stall_hold_%0d got=%h want=%h", i, obs, exp);
            end
            regs_m[3] = 32'h5000 + i;
            drive_regs();
            @(negedge clock);
        end
        tests++; exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1002};
        if (obs !== exp) begin fails++; $display("FAIL stall_hold_end got=%h want=%h", obs, exp); end
        regs_m[3] = 32'hABCD0003;
        drive_regs();
        bus.out_ready = 1'b1;
        @(negedge clock);
        tests++; exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hABCD0003};
        if (obs !== exp) begin fails++; $display("FAIL stall_beat1 got=%h want=%h", obs, exp); end
        @(negedge clock);
        tests++;
        if (obs[36:35] !== 2'b10) begin
            fails++; $display("FAIL stall_no_dup got=%b want=10", obs[36:35]);
        end
        set_regs_base();
    endtask

    task automatic test_single_empty();
        bus.out_ready = 1'b1;
        start_req(4'd5, 4'd0, 32'h0);
        @(negedge clock);
        tests++; exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1004};
        if (obs !== exp) begin fails++; $display("FAIL single_beat got=%h want=%h", obs, exp); end
        @(negedge clock);
        tests++;
        if (obs[36:35] !== 2'b10) begin
            fails++; $display("FAIL single_done got=%b want=10", obs[36:35]);
        end
        start_req(4'd0, 4'd0, 32'h0);
        tests++;
        if (obs[36:35] !== 2'b00) begin
            fails++; $display("FAIL empty_busy got=%b want=00", obs[36:35]);
        end
        @(negedge clock);
        tests++;
        if (obs[36:35] !== 2'b10) begin
            fails++; $display("FAIL empty_ready got=%b want=10", obs[36:35]);
        end
        @(negedge clock);
        tests++;
        if (obs[36:35] !== 2'b10) begin
            fails++; $display("FAIL empty_no_beat got=%b want=10", obs[36:35]);
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        start_req(4'd1, 4'd2, 32'h0);
        @(negedge clock);
        tests++; exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000};
        if (obs !== exp) begin fails++; $display("FAIL flush_pre got=%h want=%h", obs, exp); end
        bus.flush = 1'b1; bus.start = 1'b1; bus.sel_1 = 4'd6; bus.sel_2 = 4'd0;
        @(negedge clock);
        bus.flush = 1'b0; bus.start = 1'b0;
        tests++; exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000};
        if (obs !== exp) begin fails++; $display("FAIL flush_op2 got=%h want=%h", obs, exp); end
        @(negedge clock);
        tests++;
        if (obs[36:35] !== 2'b10) begin
            fails++; $display("FAIL flush_op2_idle got=%b want=10", obs[36:35]);
        end
        // Collision while idle: flush must block acceptance.
        bus.flush = 1'b1; bus.start = 1'b1; bus.sel_1 = 4'd6; bus.sel_2 = 4'd0;
        @(negedge clock);
        bus.flush = 1'b0; bus.start = 1'b0;
        tests++;
        if (obs[36:35] !== 2'b10) begin
            fails++; $display("FAIL flush_idle_start got=%b want=10", obs[36:35]);
        end
        @(negedge clock);
        tests++;
        if (obs[36:35] !== 2'b10) begin
            fails++; $display("FAIL flush_idle_no_beat got=%b want=10", obs[36:35]);
        end
        bus.out_ready = 1'b1;
        start_req(4'd6, 4'd0, 32'h0);
        @(negedge clock);
        tests++; exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1005};
        if (obs !== exp) begin fails++; $display("FAIL flush_after got=%h want=%h", obs, exp); end
        @(negedge clock);
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        start_req(4'd2, 4'd3, 32'h0);
        @(negedge clock);
        tests++; exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1001};
        if (obs !== exp) begin fails++; $display("FAIL areset_pre got=%h want=%h", obs, exp); end
        #2 reset = 1'b1;
        #1;
        tests++; exp = {1'b1, 36'h0};
        if (obs !== exp) begin fails++; $display("FAIL areset_now got=%h want=%h", obs, exp); end
        #1 reset = 1'b0;
        @(negedge clock);
        tests++; exp = {1'b1, 36'h0};
        if (obs !== exp) begin fails++; $display("FAIL areset_after got=%h want=%h", obs, exp); end
        bus.out_ready = 1'b1;
        start_req(4'd2, 4'd3, 32'h0);
        @(negedge clock);
        tests++; exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1001};
        if (obs !== exp) begin fails++; $display("FAIL areset_req0 got=%h want=%h", obs, exp); end
        @(negedge clock);
        tests++; exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1002};
        if (obs !== exp) begin fails++; $display("FAIL areset_req1 got=%h want=%h", obs, exp); end
        @(negedge clock);
    endtask

    task automatic test_random();
        logic [35:0] q[$];
        logic [35:0] want;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [31:0] imm;
        int          cyc;
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 8; k++) regs_m[k] = $urandom;
            drive_regs();
            s1  = 4'($urandom_range(0, 15));
            s2  = 4'($urandom_range(0, 15));
            imm = $urandom;
            q.delete();
            if (s1 != 4'd0) q.push_back(beat_of(s1, 1'b0, imm));
            if (s2 != 4'd0) q.push_back(beat_of(s2, 1'b1, imm));
            bus.out_ready = 1'($urandom);
            start_req(s1, s2, imm);
            cyc = 0;
            while (!(bus.ready && !bus.out_valid) && cyc < 60) begin
                bus.out_ready = 1'($urandom);
                if (bus.out_valid && bus.out_ready) begin
                    tests++;
                    if (q.size() == 0) begin
                        fails++; $display("FAIL random_%0d extra beat got=%h", r, obs[35:0]);
                    end else begin
                        want = q.pop_front();
                        if (obs[35:0] !== want) begin
                            fails++;
                            $display("FAIL random_%0d beat sel=%h/%h got=%h want=%h",
                                     r, s1, s2, obs[35:0], want);
                        end
                    end
                end
                @(negedge clock);
                cyc++;
            end
            tests++;
            if (cyc >= 60 || q.size() != 0) begin
                fails++;
                $display("FAIL random_%0d drain got cycles=%0d left=%0d want left=0",
                         r, cyc, q.size());
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        bus.sel_1     = '0;
        bus.sel_2     = '0;
        bus.imm_data  = '0;
        bus.regs_in   = '0;
        test_reset();
        test_two_regs();
        test_imm_err();
        test_backpressure();
        test_single_empty();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/operand_select_seq.md
Name: operand_select_seq

Overview:
- Parametrised, sequenced successor of the phase-gated register-output selector.
- Accepts one operand-fetch request carrying up to two register selectors. Emits the selected values one per beat over a valid/ready stream, in order: operand 0, then operand 1.
- Sits between the decoder/phase controller and the ALU/memory-address path.
- Replaces the fixed phase-gated selection with a start/ready handshake, a registered output, an immediate code, an error flag and flush.

Parameters:
- DATA_WIDTH, 32: width of each register and of the output.
- NUM_REGS, 8: number of registers on regs_in.
- SEL_WIDTH, 4: selector width.
- IMM_CODE, 4'hF: selector value that means "immediate operand".

Ports:
- clock  in  1: system clock, rising edge.
- reset  in  1: asynchronous, active-high reset.
- start  in  1: request strobe; accepted only when ready=1.
- ready  out  1: block is in IDLE and can accept start.
- sel_1  in  SEL_WIDTH: first operand selector, captured on accept.
- sel_2  in  SEL_WIDTH: second operand selector, captured on accept; 0 means no second operand.
- imm_data  in  DATA_WIDTH: immediate value, captured on accept.
- regs_in  in  NUM_REGS*DATA_WIDTH: flattened register file; register k is at bits [k*DATA_WIDTH +: DATA_WIDTH].
- flush  in  1: synchronous abort.
- out_data  out  DATA_WIDTH: operand value, registered.
- out_valid  out  1: out_data is valid.
- out_ready  in  1: consumer accepts the beat.
- out_index  out  1: 0 = operand from sel_1, 1 = operand from sel_2.
- out_imm  out  1: the beat is the immediate.
- out_err  out  1: the selector was out of range.

Behaviour:
- Reset (async, active-high): state=IDLE, out_data=0, out_valid=0, out_index=0, out_imm=0, out_err=0, latched selectors and immediate = 0. ready=1 once reset is released.
- Selector decode for value s:
  - s == IMM_CODE: value = latched imm, out_imm=1.
  - 1 <= s <= NUM_REGS: value = regs_in register s-1, sampled live in the load cycle, not at accept.
  - s > NUM_REGS and s != IMM_CODE: value = 0, out_err=1.
  - s == 0: no operand; nothing is emitted.
- Stalled: out_valid=1 and out_ready=0. While stalled, out_data and all out_* flags hold, and the FSM does not advance.
- States: IDLE, OP1, OP2.
  - IDLE: ready=1. If start=1, latch sel_1, sel_2 and imm_data, then go to OP1. If start=0, remain in IDLE.
  - OP1: if not stalled and sel_1 != 0, load the sel_1 decode with out_index=0 and set out_valid=1. Then, if not stalled, go to OP2 when sel_2 != 0, else to IDLE. If stalled, remain in OP1.
  - OP2: if not stalled, load the sel_2 decode with out_index=1 and set out_valid=1, then go to IDLE. If stalled, remain in OP2.
- out_valid clears on an out_ready handshake unless a new beat is loaded in the same cycle. A load in the same cycle as a handshake is legal and gives back-to-back beats.
- Latency:
  - start accepted in cycle t, sel_1 != 0: operand 0 valid from cycle t+2.
  - Operand 1 valid from cycle t+3 if out_ready was held high.
  - ready returns in cycle t+3 for a two-operand request, t+2 for a one-operand request.
- start while ready=0: ignored.
- A request with sel_1=0 and sel_2=0 passes through OP1 and back to IDLE with no beat emitted.
- flush: next edge forces state=IDLE and out_valid=0; the other outputs hold. flush wins over start, loads and handshakes in the same cycle.
- Reset asserted mid-request: immediate return to the reset values; the in-flight request is discarded.
- The output is fully registered: no combinational path from regs_in, start or out_ready to any output.

Test Plan:
- Two registers, consumer always ready:
  - Stimulus: regs 0..7 = 32'h1000+k; start with sel_1=1, sel_2=2, out_ready=1.
  - Required: beat (32'h1000, idx0) at t+2, beat (32'h1001, idx1) at t+3, ready=1 at t+3.
- Immediate plus out-of-range:
  - Stimulus: sel_1=4'hF, imm=32'hDEADBEEF, sel_2=4'h9.
  - Required: beat 0 = DEADBEEF with out_imm=1; beat 1 = 0 with out_err=1, out_imm=0.
- Backpressure:
  - Stimulus: sel_1=3, sel_2=4, out_ready=0 for 5 cycles after the first beat; regs_in changes during the stall.
  - Required: beat 0 = 32'h1002 held stable throughout; beat 1 = the register-3 value sampled when its load occurs; no beat lost or duplicated.
- Single operand and empty request:
  - Stimulus: sel_1=5, sel_2=0; then a request with sel_1=0, sel_2=0.
  - Required: one beat 32'h1004 idx0 and ready back at t+2; the empty request emits no beat and ready returns at t+2.
- Flush/start collision:
  - Stimulus: flush asserted in OP2 during a stall; in the same cycle, start=1 is driven.
  - Required: next cycle IDLE, out_valid=0, start not accepted; a later start behaves normally.
- Async reset mid-request:
  - Stimulus: reset pulsed between clock edges while out_valid=1.
  - Required: all outputs return to reset values immediately without a clock edge; ready=1 after release.
